// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative RV32M unit.
interface muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, fixed 34-cycle latency from acceptance to done.
module muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ITERS = 32
) (
  input  logic          clk,
  input  logic          reset,
  muldiv_unit_if.slave  bus
);
  localparam int unsigned CW = $clog2(ITERS);
  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            neg_q, neg_d, sa_q, sa_d, dz_q, dz_d, ovf_q, ovf_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_out_q, rd_out_d;

  // Operand conditioning at acceptance
  logic            sgn_a_en, sgn_b_en, in_sa, in_sb;
  logic [XLEN-1:0] in_mag_a, in_mag_b;
  // One iteration of each algorithm
  logic [XLEN:0]   mul_sum, div_shift, div_trial;
  logic            div_ge;
  // Final sign correction and selection
  logic [PW-1:0]   prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, a_val, fin_res;

  always_comb begin
    sgn_a_en  = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
    sgn_b_en  = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
    in_sa     = sgn_a_en && bus.op_a[XLEN-1];
    in_sb     = sgn_b_en && bus.op_b[XLEN-1];
    in_mag_a  = in_sa ? -bus.op_a : bus.op_a;
    in_mag_b  = in_sb ? -bus.op_b : bus.op_b;

    mul_sum   = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mag_a_q : XLEN'(0))};
    // Remainder stays below the divisor, so bit XLEN of the trial is the borrow
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_trial = div_shift - {1'b0, mag_b_q};
    div_ge    = ~div_trial[XLEN];

    prod      = {hi_q, lo_q};
    prod_s    = neg_q ? -prod : prod;
    quo_s     = neg_q ? -lo_q : lo_q;
    rem_s     = sa_q ? -hi_q : hi_q;
    a_val     = sa_q ? -mag_a_q : mag_a_q;

    unique case (op_q)
      3'd0:    fin_res = prod_s[XLEN-1:0];
      3'd4:    fin_res = dz_q ? '1 : (ovf_q ? {1'b1, {(XLEN-1){1'b0}}} : quo_s);
      3'd5:    fin_res = dz_q ? '1 : quo_s;
      3'd6:    fin_res = dz_q ? a_val : (ovf_q ? '0 : rem_s);
      3'd7:    fin_res = dz_q ? a_val : rem_s;
      default: fin_res = prod_s[PW-1:XLEN];
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    mag_a_d  = mag_a_q;
    mag_b_d  = mag_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    rd_out_d = rd_out_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
          op_d    = bus.funct3;
          rd_d    = bus.rd_in;
          mag_a_d = in_mag_a;
          mag_b_d = in_mag_b;
          hi_d    = '0;
          lo_d    = bus.funct3[2] ? in_mag_a : in_mag_b;
          neg_d   = in_sa ^ in_sb;
          sa_d    = in_sa;
          dz_d    = (bus.op_b == '0);
          ovf_d   = (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (op_q[2]) begin
          hi_d = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], div_ge};
        end else begin
          hi_d = mul_sum[XLEN:1];
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITERS - 1)) state_d = FIN;
      end
      FIN: begin
        result_d = fin_res;
        rd_out_d = rd_q;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      mag_a_q  <= mag_a_d;
      mag_b_q  <= mag_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, boundary cases,
// start-while-busy, back-to-back start, mid-operation reset and random ops.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_unit_if bus ();
  muldiv_unit dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int unsigned due;
    int          id;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int          busy_cnt = 0;
  int          next_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference using native 64-bit and signed arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64, sb64, p;
    logic [63:0]        ua64, ub64, up;
    logic               ovf;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin up = ua64 * ub64; return up[31:0]; end
      3'd1: begin p = sa64 * sb64; return p[63:32]; end
      3'd2: begin p = sa64 * $signed(ub64); return p[63:32]; end
      3'd3: begin up = ua64 * ub64; return up[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Caller is at a negedge; acceptance happens on the next posedge
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp);
    exp_t e;
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    e.res = exp;
    e.rd  = rd;
    e.due = cyc + 34;
    e.id  = next_id;
    next_id++;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op_a  = $urandom;
    bus.op_b  = $urandom;
    bus.rd_in = 5'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) check("timeout_pending", 64'(sb_q.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp);
    issue(f, a, b, rd, exp);
    wait_idle();
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        check("busy_at_done", 64'(bus.busy), 64'd0);
        if (sb_q.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("result_%0d", e.id), 64'(bus.result), 64'(e.res));
          check($sformatf("rd_%0d", e.id), 64'(bus.rd_out), 64'(e.rd));
          check($sformatf("latency_%0d", e.id), 64'(cyc), 64'(e.due));
          check($sformatf("busy_len_%0d", e.id), 64'(busy_cnt), 64'd33);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int          seen;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_rd", 64'(bus.rd_out), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB);
    check("result_hold", 64'(bus.result), 64'hFFFF_FFEB);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE);
    run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 5'd4, 32'hFFFF_FFFA);
    run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 5'd5, 32'hFFFF_FFFE);
    run_op(3'd5, 32'd20, 32'd3, 5'd6, 32'd6);
    run_op(3'd7, 32'd20, 32'd3, 5'd7, 32'd2);
    run_op(3'd4, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF);
    run_op(3'd7, 32'd5, 32'd0, 5'd9, 32'd5);
    run_op(3'd4, 32'hFFFF_FFF6, 32'd0, 5'd12, 32'hFFFF_FFFF);
    run_op(3'd6, 32'hFFFF_FFF6, 32'd0, 5'd13, 32'hFFFF_FFF6);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0);

    // start pulses while busy must be dropped
    issue(3'd5, 32'd100, 32'd7, 5'd15, 32'd14);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd9; bus.op_b = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    // start on the done cycle is accepted immediately
    issue(3'd0, 32'd123, 32'd456, 5'd16, 32'd56088);
    seen = 0;
    for (int i = 0; i < 100 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1;
    end
    check("done_seen_b2b", 64'(seen), 64'd1);
    issue(3'd7, 32'd1000, 32'd33, 5'd17, 32'd10);
    wait_idle();

    // reset in the middle of a divide aborts it silently
    issue(3'd4, 32'd1000, 32'd7, 5'd18, 32'd142);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_result", 64'(bus.result), 64'd0);
    reset = 1'b0;
    sb_q.delete();
    busy_cnt = 0;
    repeat (40) @(negedge clk);
    run_op(3'd0, 32'd6, 32'd7, 5'd19, 32'd42);

    for (int n = 0; n < 12; n++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (n % 5 == 4) ? 32'd0 : $urandom;
      if (n % 3 == 1) b = b >> $urandom_range(4, 28);
      run_op(f, a, b, 5'($urandom), ref_model(f, a, b));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file. It takes data_rs1/data_rs2 operands and an M-extension funct3, and runs a fixed-latency shift-add or restoring-divide sequence. It returns the 32-bit result with its destination register index, which writeback drives into the register file write port (data_rd/addr_rd/write_enable). Control stalls the PC while busy is high.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
ITERS, 32, iteration cycles per operation (must equal XLEN)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op_a  input  32  rs1 value (data_rs1)
op_b  input  32  rs2 value (data_rs2)
rd_in  input  5  destination register index
busy  output  1  high from the cycle after acceptance until done
done  output  1  one-cycle pulse; result/rd_out valid and write-back allowed
result  output  32  operation result, held until next acceptance
rd_out  output  5  latched rd_in, held with result

Behaviour:
- One clock, synchronous active-high reset. Reset values: state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0. Reset mid-operation aborts it and produces no done pulse.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 at edge N latches funct3, rd_in, operand magnitudes and sign flags; counter=0; go to RUN; busy=1 from N.
  - Special-case flags (div-by-zero, signed overflow) are computed here.
- RUN: one iteration per edge. After the 32nd iteration (edge N+32), go to FIN.
- FIN (edge N+33):
  - Apply sign correction and select the result; register result and rd_out.
  - Set done=1 and busy=0 for exactly one cycle; return to IDLE.
- Fixed latency for all eight ops and all operand values: done is high in the cycle after edge N+33.
- start while busy=1 is ignored, with no queuing. start in the same cycle as done (state IDLE on that edge) is accepted normally.
- Multiply:
  - 64-bit product built by shift-add on magnitudes, then negated if the signs differ.
  - MUL returns low 32 bits. MULH, MULHSU and MULHU return high 32 bits.
  - Signedness: MULH treats both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
- Divide (restoring, on magnitudes):
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
- Boundary cases (RISC-V spec), still at full latency:
  - op_b=0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
  - DIV 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM of the same returns 0.
- op_a and op_b may change after acceptance with no effect.
- result and rd_out hold their value until the next FIN.

Test Plan:
- Reset, then MUL a=7, b=-3 (0xFFFFFFFD) -> busy high for 33 cycles, done pulse once, result=0xFFFFFFEB, rd_out=rd_in.
- MULH/MULHSU/MULHU with a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE respectively.
- DIV -20/3 -> 0xFFFFFFFA; REM -20/3 -> 0xFFFFFFFE; DIVU 20/3 -> 6; REMU 20/3 -> 2.
- Div-by-zero: DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5. Overflow: DIV 0x80000000/-1 -> 0x80000000, REM -> 0. All at same latency.
- Second start pulsed at cycles 5 and 20 of a running op -> ignored, single done. start asserted on the done cycle -> new op accepted, its done 34 cycles later.
- Assert reset at cycle 10 of a DIV -> busy=0, done=0, result=0 next cycle, no done pulse. A following MUL 6*7 returns 42.
